// File: rtl/if_fetch_redirect_if.sv
// Bundle of the fetch-stage signals: ID branch decision, stalls, instruction
// memory port, IF/ID pipeline register outputs and performance counters.
interface if_fetch_redirect_if #(
  parameter int CNT_W = 16
);
  logic             ID_br_ctrl;
  logic [31:0]      ID_br_target;
  logic             br_hazard_stall;
  logic             ld_stall;
  logic [31:0]      imem_inst;
  logic [31:0]      imem_addr;
  logic             imem_en;
  logic [31:0]      IFID_inst;
  logic [31:0]      IFID_pc;
  logic             IFID_valid;
  logic [CNT_W-1:0] br_taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  ID_br_ctrl, ID_br_target, br_hazard_stall, ld_stall, imem_inst,
    output imem_addr, imem_en, IFID_inst, IFID_pc, IFID_valid,
           br_taken_cnt, stall_cnt
  );

  modport slave (
    output ID_br_ctrl, ID_br_target, br_hazard_stall, ld_stall, imem_inst,
    input  imem_addr, imem_en, IFID_inst, IFID_pc, IFID_valid,
           br_taken_cnt, stall_cnt
  );
endinterface

// File: rtl/if_fetch_redirect.sv
// Instruction-fetch controller: PC, IF/ID register, taken-branch redirect with
// a one-cycle bubble, stall holding and saturating performance counters.
module if_fetch_redirect #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic                 clk,
  input logic                 reset,
  if_fetch_redirect_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        ifid_inst_q, ifid_inst_d;
  logic [31:0]        ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               imem_en_q, imem_en_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               stall;

  assign stall = bus.br_hazard_stall | bus.ld_stall;

  // ID_br_ctrl is only honoured in RUN: it is undefined under a hazard stall
  // and ID holds the bubble while in REDIRECT.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    br_cnt_d     = br_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN, REDIRECT: begin
        if (stall) begin
          stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end else if (state_q == RUN && bus.ID_br_ctrl) begin
          pc_d         = bus.ID_br_target;
          ifid_inst_d  = NOP_INST;
          ifid_pc_d    = 32'h0;
          ifid_valid_d = 1'b0;
          br_cnt_d     = (br_cnt_q == '1) ? br_cnt_q : br_cnt_q + 1'b1;
          state_d      = REDIRECT;
        end else begin
          ifid_inst_d  = bus.imem_inst;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + PC_STEP;
          state_d      = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    imem_en_d = (state_d != BOOT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= PC_RESET;
      ifid_inst_q  <= NOP_INST;
      ifid_pc_q    <= 32'h0;
      ifid_valid_q <= 1'b0;
      imem_en_q    <= 1'b0;
      br_cnt_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      imem_en_q    <= imem_en_d;
      br_cnt_q     <= br_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.imem_en      = imem_en_q;
  assign bus.IFID_inst    = ifid_inst_q;
  assign bus.IFID_pc      = ifid_pc_q;
  assign bus.IFID_valid   = ifid_valid_q;
  assign bus.br_taken_cnt = br_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule
